// File: rtl/spmv_pair_feeder.sv
// Producer for a dual-lane SpMV processing element: packs column-ordered
// nonzeros two per beat, drops zero entries, pads odd columns, counts overlaps.
module spmv_pair_feeder #(
    parameter int NUM_COLS = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [31:0]      vec_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_val,
    input  logic [11:0]      in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      val1,
    output logic [31:0]      val2,
    output logic [11:0]      rowIdx1,
    output logic [11:0]      rowIdx2,
    output logic             tag1,
    output logic             tag2,
    output logic [31:0]      vec,
    input  logic             overlap,
    output logic [CNT_W-1:0] ovl_cnt,
    output logic             busy,
    output logic             done
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEC,
        S_A,
        S_B,
        S_EMIT
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col_cnt;
    logic             col_end;

    logic vec_fire;
    logic in_fire;
    logic out_fire;
    logic in_zero;
    logic last_col;

    assign vec_fire = vec_valid & vec_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // Bitwise compare, so -0.0 (0x80000000) counts as a real nonzero.
    assign in_zero  = (in_val == 32'd0);
    assign last_col = (col_cnt == LAST_COL);

    // Lane tags identify the lanes, not the data; they never change.
    assign tag1 = 1'b0;
    assign tag2 = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            col_cnt   <= '0;
            col_end   <= 1'b0;
            vec_ready <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            val1      <= '0;
            val2      <= '0;
            rowIdx1   <= '0;
            rowIdx2   <= '0;
            vec       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col_cnt   <= '0;
                        vec_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_VEC;
                    end
                end

                S_VEC: begin
                    if (vec_fire) begin
                        vec       <= vec_data;
                        vec_ready <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_A;
                    end
                end

                S_A: begin
                    if (in_fire) begin
                        if (!in_zero) begin
                            val1    <= in_val;
                            rowIdx1 <= in_row;
                            if (in_last) begin
                                val2      <= '0;
                                rowIdx2   <= '0;
                                col_end   <= 1'b1;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= S_EMIT;
                            end else begin
                                state <= S_B;
                            end
                        end else if (in_last) begin
                            // Column held only zeros: nothing to emit, move on.
                            in_ready <= 1'b0;
                            if (last_col) begin
                                done    <= 1'b1;
                                col_cnt <= '0;
                                busy    <= 1'b0;
                                state   <= S_IDLE;
                            end else begin
                                col_cnt   <= col_cnt + COL_W'(1);
                                vec_ready <= 1'b1;
                                state     <= S_VEC;
                            end
                        end
                    end
                end

                S_B: begin
                    if (in_fire && (!in_zero || in_last)) begin
                        val2      <= in_zero ? 32'd0 : in_val;
                        rowIdx2   <= in_zero ? 12'd0 : in_row;
                        col_end   <= in_last;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (!col_end) begin
                            in_ready <= 1'b1;
                            state    <= S_A;
                        end else if (last_col) begin
                            done    <= 1'b1;
                            col_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            col_cnt   <= col_cnt + COL_W'(1);
                            vec_ready <= 1'b1;
                            state     <= S_VEC;
                        end
                    end
                end

                default: begin
                    vec_ready <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Overlap count survives IDLE so it can be read after done; start clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovl_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            ovl_cnt <= '0;
        end else if (overlap && busy && (ovl_cnt != {CNT_W{1'b1}})) begin
            ovl_cnt <= ovl_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/spmv_pair_feeder.md
Name: spmv_pair_feeder

Overview:
- Producer side of the systolic SpMV processing-element lane interface.
- Takes a column-ordered stream of sparse-matrix nonzeros plus one dense-vector element per column.
- Packs nonzeros two per beat into the PE's dual lanes (val1/val2, rowIdx1/rowIdx2, tag1/tag2, vec) under a valid/ready handshake.
- Drops zero-valued entries, pads odd-length columns, and counts the PE's overlap reports.

Parameters:
- NUM_COLS, 64, number of matrix columns per run; done pulses after the last one.
- CNT_W, 16, width of the saturating overlap counter.

Ports:
- clk  input  1  clock; all state is updated on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a run from IDLE.
- vec_valid  input  1  a vector element is offered.
- vec_ready  output  1  feeder accepts the vector element.
- vec_data  input  32  FP32 vector element for the current column.
- in_valid  input  1  a nonzero entry is offered.
- in_ready  output  1  feeder accepts the entry.
- in_val  input  32  FP32 matrix value.
- in_row  input  12  row index of the entry.
- in_last  input  1  the entry is the last one of its column.
- out_valid  output  1  a lane beat is presented.
- out_ready  input  1  the PE side accepts the beat.
- val1, val2  output  32 each  lane values.
- rowIdx1, rowIdx2  output  12 each  lane row indices.
- tag1, tag2  output  1 each  lane tags.
- vec  output  32  vector element for the beat.
- overlap  input  1  PE overlap flag.
- ovl_cnt  output  CNT_W  saturating count of cycles with overlap high while busy.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse at the end of a run.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0, except tag2=1.
  - Column counter col_cnt=0 and ovl_cnt=0.
- All outputs are registered. A handshake completes when valid and ready are both 1 on the same rising edge.
- State machine:
  - IDLE: start=1 clears col_cnt and ovl_cnt, then -> VEC. start is ignored in every other state.
  - VEC: vec_ready=1. On handshake, latch vec_data into vec_reg -> A.
  - A: in_ready=1. On handshake:
    - in_val!=0 and in_last=0: store into slot A -> B.
    - in_val!=0 and in_last=1: store into A; load slot B with val 0, row 0; set col_end -> EMIT.
    - in_val==0 and in_last=0: drop the entry; stay in A.
    - in_val==0 and in_last=1: empty column, no beat is emitted; advance the column (see end-of-column).
  - B: in_ready=1. On handshake:
    - in_val!=0: store into B; col_end=in_last -> EMIT.
    - in_val==0 and in_last=0: drop the entry; stay in B.
    - in_val==0 and in_last=1: pad B with val 0, row 0; col_end=1 -> EMIT.
  - EMIT: out_valid=1.
    - Fields: val1/rowIdx1 from slot A, val2/rowIdx2 from slot B, vec=vec_reg, tag1=0, tag2=1.
    - All fields must hold stable while out_ready=0.
    - On handshake: out_valid drops next cycle. If col_end=0 -> A, else advance the column.
- End-of-column:
  - If col_cnt==NUM_COLS-1: done=1 for one cycle, col_cnt returns to 0 -> IDLE.
  - Otherwise: col_cnt+1 -> VEC.
- in_ready=0 and vec_ready=0 outside their own states; there is no skid, so upstream must hold its data.
- Latency: out_valid rises the cycle after the B-slot handshake, or after the A-slot handshake when in_last=1. Peak throughput is one beat per 3 cycles.
- ovl_cnt increments each cycle that overlap=1 and busy=1. It saturates at 2^CNT_W-1 and holds its value through IDLE until the next start.
- Zero detection compares all 32 bits to 0, so -0.0 (0x80000000) is treated as nonzero.
- Reset asserted mid-run aborts immediately: no beat, no done, and the partial column is discarded.

Test Plan:
- Basic pair: start; vec 0x3F800000; entries (0x40000000, row 3), (0x40400000, row 7, last) -> one beat: val1=0x40000000, rowIdx1=3, val2=0x40400000, rowIdx2=7, vec=0x3F800000, tag1=0, tag2=1.
- Odd column: entries (0x40800000, row 5), (0x40A00000, row 6), (0x40C00000, row 9, last) -> two beats; the second has val1=0x40C00000, rowIdx1=9, val2=0, rowIdx2=0.
- Zeros and empty column: column 0 = (0, row 1, last) -> no beat and col_cnt becomes 1; column 1 = (0x3F800000, row 2), (0, row 4, last) -> one beat with val2=0.
- Backpressure: hold out_ready=0 for 5 cycles during EMIT -> all fields stable; in_ready=0 throughout; exactly one beat accepted.
- Run completion and overlap: NUM_COLS=2, drive overlap=1 for 3 busy cycles -> done pulses once after the last beat, ovl_cnt=3, busy=0 afterwards. CNT_W=2 with 5 overlap cycles -> ovl_cnt=3.
- Reset mid-run: assert reset_n=0 while in EMIT -> out_valid, val1 and ovl_cnt read 0 and tag2 reads 1 immediately, before the next clock edge.
